// File: rtl/axis_oled_text_sink_pkg.sv
// Shared constants, control codes and state encoding for the OLED text sink.
// The text frame is ROWS x COLS cells of 8-bit ASCII. Column 0 sits in the
// most significant byte of each row bus.
package oled_text_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 16;
  localparam int CHAR_W = 8;
  localparam int ROW_W  = COLS * CHAR_W;
  localparam int ROW_AW = $clog2(ROWS);
  localparam int COL_AW = $clog2(COLS);
  localparam int BIT_AW = $clog2(ROW_W);

  localparam logic [CHAR_W-1:0] FILL_CHAR = 8'h20;
  localparam logic [CHAR_W-1:0] BAD_CHAR  = 8'h3F;

  localparam logic [CHAR_W-1:0] CH_BS = 8'h08;
  localparam logic [CHAR_W-1:0] CH_LF = 8'h0A;
  localparam logic [CHAR_W-1:0] CH_FF = 8'h0C;
  localparam logic [CHAR_W-1:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Printable ASCII range; space through tilde.
  function automatic logic is_printable(input logic [CHAR_W-1:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  // True for the four bytes that steer the cursor instead of writing a cell.
  function automatic logic is_control(input logic [CHAR_W-1:0] b);
    return (b == CH_LF) || (b == CH_CR) || (b == CH_BS) || (b == CH_FF);
  endfunction

endpackage

// File: rtl/axis_oled_text_sink.sv
// AXI4-Stream slave that assembles an ASCII byte stream into a ROWS x COLS
// text frame. Bytes are written into a shadow buffer; the beat carrying TLAST
// moves the FSM to COMMIT, which copies every shadow row to the output rows
// in a single edge so the display never sees a half-written frame.
module axis_oled_text_sink
  import oled_text_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CHAR_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [ROW_W-1:0]  str1,
  output logic [ROW_W-1:0]  str2,
  output logic [ROW_W-1:0]  str3,
  output logic [ROW_W-1:0]  str4,
  output logic              frame_done,
  output logic              overflow,
  output logic [ROW_AW-1:0] cursor_row,
  output logic [COL_AW-1:0] cursor_col
);

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);
  localparam logic [COL_AW-1:0] LAST_COL = COL_AW'(COLS - 1);
  localparam logic [ROW_W-1:0]  FILL_ROW = {COLS{FILL_CHAR}};

  state_t              state;
  logic [ROW_AW-1:0]   clr_row;
  logic                full;
  logic                ff_pend;
  logic                tready_r;

  logic [ROW_W-1:0]    shadow [ROWS];
  logic [ROW_W-1:0]    str_r  [ROWS];

  logic                hs;
  logic                put;
  logic                wr;
  logic [CHAR_W-1:0]   ch;
  logic [BIT_AW-1:0]   bit_lo;

  // Beat decode: which byte lands in the cell and where inside the row bus.
  // Column c occupies bits [(COLS-1-c)*8 +: 8]; with COLS a power of two that
  // offset is simply the inverted column index shifted by three.
  always_comb begin
    hs     = s_axis_tvalid && tready_r;
    ch     = is_printable(s_axis_tdata) ? s_axis_tdata : BAD_CHAR;
    put    = hs && !is_control(s_axis_tdata);
    wr     = put && !full;
    bit_lo = {~cursor_col, 3'b000};
  end

  // Control FSM: clear sweep, byte acceptance with cursor tracking, commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR;
      clr_row    <= '0;
      tready_r   <= 1'b0;
      cursor_row <= '0;
      cursor_col <= '0;
      full       <= 1'b0;
      ff_pend    <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      unique case (state)
        CLEAR: begin
          cursor_row <= '0;
          cursor_col <= '0;
          full       <= 1'b0;
          ff_pend    <= 1'b0;
          if (clr_row == LAST_ROW) begin
            clr_row  <= '0;
            state    <= RUN;
            tready_r <= 1'b1;
          end else begin
            clr_row  <= clr_row + 1'b1;
          end
        end

        RUN: begin
          if (hs) begin
            unique case (s_axis_tdata)
              CH_LF: begin
                // Line feed on the last row has nowhere to go: the frame is full.
                if (cursor_row == LAST_ROW) begin
                  full <= 1'b1;
                end else begin
                  cursor_row <= cursor_row + 1'b1;
                  cursor_col <= '0;
                end
              end
              CH_CR: cursor_col <= '0;
              CH_BS: begin
                if (cursor_col != '0) cursor_col <= cursor_col - 1'b1;
              end
              CH_FF: begin
                cursor_row <= '0;
                cursor_col <= '0;
              end
              default: begin
                if (full) begin
                  overflow <= 1'b1;
                end else if (cursor_col == LAST_COL) begin
                  // Writing the very last cell leaves the cursor parked on it.
                  if (cursor_row == LAST_ROW) begin
                    full <= 1'b1;
                  end else begin
                    cursor_row <= cursor_row + 1'b1;
                    cursor_col <= '0;
                  end
                end else begin
                  cursor_col <= cursor_col + 1'b1;
                end
              end
            endcase

            // TLAST wins over form feed; a form feed on the last beat is
            // remembered so the commit publishes a blank frame.
            if (s_axis_tlast) begin
              state    <= COMMIT;
              tready_r <= 1'b0;
              ff_pend  <= (s_axis_tdata == CH_FF);
            end else if (s_axis_tdata == CH_FF) begin
              state    <= CLEAR;
              tready_r <= 1'b0;
            end
          end
        end

        COMMIT: begin
          frame_done <= 1'b1;
          state      <= CLEAR;
        end

        default: begin
          state    <= CLEAR;
          clr_row  <= '0;
          tready_r <= 1'b0;
        end
      endcase
    end
  end

  // Shadow buffer: one row blanked per CLEAR cycle, single-cell writes in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) shadow[r] <= FILL_ROW;
    end else if (state == CLEAR) begin
      shadow[clr_row] <= FILL_ROW;
    end else if (wr) begin
      shadow[cursor_row][bit_lo +: CHAR_W] <= ch;
    end
  end

  // Output rows: updated only on the COMMIT edge, all rows together.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) str_r[r] <= FILL_ROW;
    end else if (state == COMMIT) begin
      for (int r = 0; r < ROWS; r++) str_r[r] <= ff_pend ? FILL_ROW : shadow[r];
    end
  end

  assign s_axis_tready = tready_r;
  assign str1          = str_r[0];
  assign str2          = str_r[1];
  assign str3          = str_r[2];
  assign str4          = str_r[3];

endmodule

// File: tb/tb_axis_oled_text_sink.sv
// Directed bench for axis_oled_text_sink. Inputs change on the falling edge,
// outputs are sampled on the falling edge, so no sample races the active edge.
module tb_axis_oled_text_sink;
  import oled_text_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       tdata = '0;
  logic             tvalid = 1'b0;
  logic             tready;
  logic             tlast = 1'b0;
  logic [127:0]     str1, str2, str3, str4;
  logic             frame_done, overflow;
  logic [1:0]       cursor_row;
  logic [3:0]       cursor_col;

  int n_chk  = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  int ov_cnt = 0;

  localparam logic [127:0] BLANK = {16{8'h20}};

  always #5 clk = ~clk;

  axis_oled_text_sink dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tlast  (tlast),
    .str1          (str1),
    .str2          (str2),
    .str3          (str3),
    .str4          (str4),
    .frame_done    (frame_done),
    .overflow      (overflow),
    .cursor_row    (cursor_row),
    .cursor_col    (cursor_col)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) fd_cnt++;
      if (overflow)   ov_cnt++;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Text row padded with spaces, column 0 in the top byte.
  function automatic logic [127:0] row_of(input string s);
    logic [127:0] r;
    r = BLANK;
    for (int i = 0; i < s.len() && i < 16; i++) r[127 - 8*i -: 8] = s[i];
    return r;
  endfunction

  // One beat: present on the falling edge, hold until accepted at a rising edge.
  task automatic send(input logic [7:0] b, input logic last);
    int waited;
    @(negedge clk);
    tdata  = b;
    tlast  = last;
    tvalid = 1'b1;
    waited = 0;
    while (!tready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("send_timeout", 128'(waited), 128'd0);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = 8'hEE;
  endtask

  task automatic send_str(input string s, input logic last_on_final);
    for (int i = 0; i < s.len(); i++)
      send(s[i], last_on_final && (i == s.len() - 1));
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 128'(n), 128'd0);
  endtask

  // Called right after the TLAST beat was accepted: checks commit latency,
  // the frame_done position and the length of the tready-low window.
  task automatic commit_wait(input string tag, input logic [127:0] old1);
    int lo;
    lo = 0;
    @(negedge clk);
    check({tag, "_fd_early"}, 128'(frame_done), 128'd0);
    check({tag, "_str_hold"}, str1, old1);
    if (!tready) lo++;
    @(negedge clk);
    check({tag, "_fd_pulse"}, 128'(frame_done), 128'd1);
    if (!tready) lo++;
    for (int i = 0; i < 20 && !tready; i++) begin
      @(negedge clk);
      if (!tready) lo++;
    end
    check({tag, "_tready_low"}, 128'(lo), 128'd5);
  endtask

  initial begin
    int lo;
    int fd0;

    // 1. reset state and initial clear sweep
    repeat (3) @(negedge clk);
    check("rst_str1", str1, BLANK);
    check("rst_str2", str2, BLANK);
    check("rst_str3", str3, BLANK);
    check("rst_str4", str4, BLANK);
    check("rst_fd", 128'(frame_done), 128'd0);
    check("rst_ov", 128'(overflow), 128'd0);
    check("rst_cursor", 128'({cursor_row, cursor_col}), 128'd0);
    rst = 1'b0;
    lo  = tready ? 0 : 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tready) break;
      lo++;
    end
    check("rst_tready_low", 128'(lo), 128'd4);
    check("rst_no_fd", 128'(fd_cnt), 128'd0);

    // 2. HELLO
    send_str("HELLO", 1'b1);
    commit_wait("hello", BLANK);
    check("hello_str1", str1, {"HELLO", {11{8'h20}}});
    check("hello_str2", str2, BLANK);
    check("hello_str3", str3, BLANK);
    check("hello_str4", str4, BLANK);
    check("hello_fd_cnt", 128'(fd_cnt), 128'd1);

    // 3. row wrap after 16 columns
    send_str("ABCDEFGHIJKLMNOPQ", 1'b1);
    commit_wait("wrap", {"HELLO", {11{8'h20}}});
    check("wrap_str1", str1, row_of("ABCDEFGHIJKLMNOP"));
    check("wrap_str2_c0", 128'(str2[127:120]), 128'h51);
    check("wrap_str2", str2, row_of("Q"));
    check("wrap_str3", str3, BLANK);

    // 4. LF / CR / BS handling
    send_str("AB", 1'b0);
    send(8'h0A, 1'b0);
    send_str("CD", 1'b0);
    send(8'h0D, 1'b0);
    send("X", 1'b0);
    @(negedge clk);
    check("ctrl_cursor_x", 128'({cursor_row, cursor_col}), 128'({2'd1, 4'd1}));
    send(8'h08, 1'b0);
    send("Y", 1'b1);
    commit_wait("ctrl", row_of("ABCDEFGHIJKLMNOP"));
    check("ctrl_str1", str1, row_of("AB"));
    check("ctrl_str2", str2, row_of("YD"));
    check("ctrl_str3", str3, BLANK);

    // unsupported byte becomes '?'
    send(8'h01, 1'b0);
    send(8'h7F, 1'b0);
    send("k", 1'b1);
    commit_wait("bad", row_of("AB"));
    check("bad_str1", str1, row_of("??k"));

    // 5. fill every cell, two bytes overflow
    fd0    = fd_cnt;
    ov_cnt = 0;
    for (int i = 0; i < 65; i++) send("Z", 1'b0);
    @(negedge clk);
    check("full_cursor", 128'({cursor_row, cursor_col}), 128'({2'd3, 4'd15}));
    send("Z", 1'b1);
    commit_wait("full", row_of("??k"));
    check("full_str1", str1, {16{8'h5A}});
    check("full_str2", str2, {16{8'h5A}});
    check("full_str3", str3, {16{8'h5A}});
    check("full_str4", str4, {16{8'h5A}});
    check("full_ov_cnt", 128'(ov_cnt), 128'd2);
    check("full_fd_cnt", 128'(fd_cnt - fd0), 128'd1);

    // form feed mid-frame, then an empty LF+tlast commit
    send_str("AB", 1'b0);
    send(8'h0C, 1'b0);
    @(negedge clk);
    check("ff_tready", 128'(tready), 128'd0);
    check("ff_cursor", 128'({cursor_row, cursor_col}), 128'd0);
    send("C", 1'b0);
    send(8'h0A, 1'b1);
    commit_wait("ff", {16{8'h5A}});
    check("ff_str1", str1, row_of("C"));

    // form feed carrying tlast commits a blank frame
    send_str("HI", 1'b0);
    send(8'h0C, 1'b1);
    commit_wait("fflast", row_of("C"));
    check("fflast_str1", str1, BLANK);

    // put something visible back so the reset blanking is observable
    send_str("PQ", 1'b1);
    commit_wait("pre", BLANK);
    check("pre_str1", str1, row_of("PQ"));

    // 6. gappy partial frame, reset, then a clean frame
    fd0 = fd_cnt;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'h61 + 8'(i), 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_str1", str1, BLANK);
    check("mid_rst_tready", 128'(tready), 128'd0);
    rst = 1'b0;
    wait_ready();
    check("mid_rst_no_fd", 128'(fd_cnt - fd0), 128'd0);
    send_str("OK", 1'b1);
    commit_wait("ok", BLANK);
    check("ok_str1", str1, row_of("OK"));
    check("ok_str2", str2, BLANK);
    check("ok_fd_cnt", 128'(fd_cnt - fd0), 128'd1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
